// File: rtl/accum_dump.sv
// accum_dump: block accumulator placed after the unsigned adder.
// Sums ACC_LEN accepted samples (or fewer, on flush_i) into a wide register
// and presents the block sum on a valid/ready output. The next block keeps
// accumulating while a finished result waits for the consumer.
// Optional build macro ACCUM_SATURATE_EN: on carry out the accumulator clamps
// to all-ones for the rest of the block instead of wrapping.
// ACC_WIDTH must be >= DATA_WIDTH; ACC_LEN must lie in 2..65535.
module accum_dump #(
  parameter int DATA_WIDTH = 17,
  parameter int ACC_LEN    = 8,
  parameter int ACC_WIDTH  = 20
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  valid_i,
  output logic                  ready_o,
  input  logic                  flush_i,
  output logic [ACC_WIDTH-1:0]  sum_o,
  output logic [15:0]           count_o,
  output logic                  overflow_o,
  output logic                  valid_o,
  input  logic                  ready_i
);

  localparam logic [15:0] LEN    = 16'(ACC_LEN);
  localparam logic [15:0] LEN_M1 = 16'(ACC_LEN - 1);

  typedef enum logic {
    S_ACC  = 1'b0,
    S_HOLD = 1'b1
  } state_t;

  state_t state_reg, state_next;

  logic [ACC_WIDTH-1:0] acc_reg, acc_next;
  logic [15:0]          cnt_reg, cnt_next;
  logic                 ovf_reg, ovf_next;

  logic [ACC_WIDTH-1:0] sum_reg;
  logic [15:0]          count_reg;
  logic                 overflow_reg;

  logic                 blocked;
  logic                 accept;
  logic                 flush_ok;
  logic                 close;
  logic [ACC_WIDTH:0]   sum_wide;
  logic                 carry;
  logic [15:0]          cnt_inc;

  // A pending result that the consumer is not taking this cycle cannot be
  // overwritten, so any close is forbidden while this is high.
  assign blocked = (state_reg == S_HOLD) && !ready_i;

  // Accumulator datapath and close decision.
  // A flush while blocked is dropped: with cnt>0 ready_o is low anyway, and
  // with cnt==0 the sample is taken into the new block but the block is not
  // closed, since there is nowhere to put its result.
  always_comb begin
    accept   = valid_i && ready_o;
    flush_ok = flush_i && !blocked;
    sum_wide = {1'b0, acc_reg} + {{(ACC_WIDTH + 1 - DATA_WIDTH){1'b0}}, data_i};
    carry    = sum_wide[ACC_WIDTH];
    cnt_inc  = cnt_reg + 16'd1;
    acc_next = acc_reg;
    cnt_next = cnt_reg;
    ovf_next = ovf_reg;
    if (accept) begin
`ifdef ACCUM_SATURATE_EN
      // Once clamped, any further nonzero sample carries again, so the
      // accumulator stays at all-ones until the block closes.
      acc_next = carry ? '1 : sum_wide[ACC_WIDTH-1:0];
`else
      acc_next = sum_wide[ACC_WIDTH-1:0];
`endif
      cnt_next = cnt_inc;
      ovf_next = ovf_reg | carry;
    end
    close = (accept && (cnt_inc == LEN)) ||
            (flush_ok && ((cnt_reg != 16'd0) || accept));
  end

  // State register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg <= S_ACC;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic: a close always leaves a result pending; otherwise a
  // pending result is released when the consumer takes it.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_ACC:  if (close) state_next = S_HOLD;
      S_HOLD: begin
        if (close) begin
          state_next = S_HOLD;
        end else if (ready_i) begin
          state_next = S_ACC;
        end
      end
      default: state_next = S_ACC;
    endcase
  end

  // Output decode: stall upstream only when the coming sample or flush would
  // close a block while the previous result is still stuck.
  always_comb begin
    valid_o = (state_reg == S_HOLD);
    ready_o = !(blocked &&
                ((cnt_reg == LEN_M1) || (flush_i && (cnt_reg != 16'd0))));
  end

  // Accumulator and result registers; a close loads the result and starts
  // an empty block on the same edge.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      acc_reg      <= '0;
      cnt_reg      <= '0;
      ovf_reg      <= 1'b0;
      sum_reg      <= '0;
      count_reg    <= '0;
      overflow_reg <= 1'b0;
    end else if (close) begin
      sum_reg      <= acc_next;
      count_reg    <= cnt_next;
      overflow_reg <= ovf_next;
      acc_reg      <= '0;
      cnt_reg      <= '0;
      ovf_reg      <= 1'b0;
    end else begin
      acc_reg      <= acc_next;
      cnt_reg      <= cnt_next;
      ovf_reg      <= ovf_next;
    end
  end

  assign sum_o      = sum_reg;
  assign count_o    = count_reg;
  assign overflow_o = overflow_reg;

endmodule

// File: tb/tb_accum_dump.sv
// Testbench for accum_dump: directed scenarios plus randomized valid/ready/
// flush traffic, checked every cycle against a block-level reference model
// that keeps the exact (unbounded) block sum and derives wrap/saturate from it.
// A second, narrow instance (ACC_WIDTH=17) exercises the overflow behaviour.
module tb_accum_dump;

  localparam int DW  = 17;
  localparam int LEN = 8;
  localparam int AW  = 20;
  localparam int NAW = 17;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] data;
  logic          valid;
  logic          ready_o;
  logic          flush;
  logic [AW-1:0] sum_o;
  logic [15:0]   count_o;
  logic          overflow_o;
  logic          valid_o;
  logic          ready_in;

  logic [DW-1:0]  n_data;
  logic           n_valid;
  logic           n_ready_o;
  logic           n_flush;
  logic [NAW-1:0] n_sum_o;
  logic [15:0]    n_count_o;
  logic           n_overflow_o;
  logic           n_valid_o;
  logic           n_ready_in;

  always #5 clk = ~clk;

  accum_dump #(.DATA_WIDTH(DW), .ACC_LEN(LEN), .ACC_WIDTH(AW)) dut (
    .clk_i(clk), .rst_i(rst), .data_i(data), .valid_i(valid),
    .ready_o(ready_o), .flush_i(flush), .sum_o(sum_o), .count_o(count_o),
    .overflow_o(overflow_o), .valid_o(valid_o), .ready_i(ready_in)
  );

  accum_dump #(.DATA_WIDTH(DW), .ACC_LEN(LEN), .ACC_WIDTH(NAW)) dut_n (
    .clk_i(clk), .rst_i(rst), .data_i(n_data), .valid_i(n_valid),
    .ready_o(n_ready_o), .flush_i(n_flush), .sum_o(n_sum_o),
    .count_o(n_count_o), .overflow_o(n_overflow_o), .valid_o(n_valid_o),
    .ready_i(n_ready_in)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: exact block sum plus the result currently on offer.
  longint m_true;
  int     m_cnt;
  bit     m_pend;
  longint m_sum;
  int     m_count;
  bit     m_ovf;
  bit     last_take;

  task automatic check(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic longint model_sum(input longint t, input int w);
    longint maxv;
    maxv = (longint'(1) << w) - 1;
`ifdef ACCUM_SATURATE_EN
    return (t > maxv) ? maxv : t;
`else
    return t & maxv;
`endif
  endfunction

  function automatic bit model_ovf(input longint t, input int w);
    return t >= (longint'(1) << w);
  endfunction

  task automatic model_clear();
    m_true = 0; m_cnt = 0; m_pend = 0;
    m_sum = 0; m_count = 0; m_ovf = 0;
  endtask

  task automatic check_outputs(input string pfx);
    check({pfx, "_valid_o"},    valid_o,    m_pend);
    check({pfx, "_sum_o"},      sum_o,      m_sum);
    check({pfx, "_count_o"},    count_o,    m_count);
    check({pfx, "_overflow_o"}, overflow_o, m_ovf);
  endtask

  // One clock of the main instance: drive, check ready_o, advance model,
  // then check the registered outputs just after the edge.
  task automatic step(input bit v, input logic [DW-1:0] d, input bit f, input bit r);
    bit blocked, exp_rdy, take, close;
    @(negedge clk);
    valid = v; data = d; flush = f; ready_in = r;
    #1;
    blocked = m_pend && !r;
    exp_rdy = !(blocked && (m_cnt == LEN - 1 || (f && m_cnt > 0)));
    check("ready_o", ready_o, exp_rdy);
    take = v && exp_rdy;
    last_take = take;
    if (m_pend && r)
      $display("result taken: sum=%0d count=%0d overflow=%0d", m_sum, m_count, m_ovf);
    if (take) begin
      m_true += d;
      m_cnt++;
    end
    close = (take && m_cnt == LEN) || (f && !blocked && m_cnt > 0);
    if (close) begin
      m_sum   = model_sum(m_true, AW);
      m_ovf   = model_ovf(m_true, AW);
      m_count = m_cnt;
      m_pend  = 1;
      m_true  = 0;
      m_cnt   = 0;
    end else if (m_pend && r) begin
      m_pend = 0;
    end
    @(posedge clk);
    #1;
    check_outputs("cyc");
  endtask

  // One clock of the narrow instance (consumer always ready).
  task automatic nstep(input bit v, input logic [DW-1:0] d, input bit f);
    @(negedge clk);
    n_valid = v; n_data = d; n_flush = f;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1; valid = 0; flush = 0; ready_in = 1;
    @(posedge clk);
    #1;
    model_clear();
    check_outputs("rst");
    @(negedge clk);
    rst = 0;
  endtask

  initial begin
    int accepted;
    int cyc;
    longint nt;
    rst = 1; valid = 0; data = '0; flush = 0; ready_in = 1;
    n_valid = 0; n_data = '0; n_flush = 0; n_ready_in = 1;
    model_clear();
    repeat (3) @(posedge clk);
    #1;
    check_outputs("reset");
    check("reset_ready_o", ready_o, 1);
    check("reset_n_valid_o", n_valid_o, 0);
    @(negedge clk);
    rst = 0;

    // Narrow instance: overflow on 0x1FFFF + 0x1FFFF.
    nstep(1, 17'h1FFFF, 0);
    nstep(1, 17'h1FFFF, 1);
    nt = 64'h3FFFE;
    check("ovf_valid", n_valid_o, 1);
    check("ovf_sum", n_sum_o, model_sum(nt, NAW));
    check("ovf_count", n_count_o, 2);
    check("ovf_flag", n_overflow_o, 1);
    // Exactly full, no carry: flag must clear with the new block.
    nstep(1, 17'h10000, 0);
    nstep(1, 17'h0FFFF, 1);
    check("full_sum", n_sum_o, 17'h1FFFF);
    check("full_flag", n_overflow_o, 0);
    // Carry then further samples: wrap continues, saturation sticks.
    nstep(1, 17'h1FFFF, 0);
    nstep(1, 17'h00001, 0);
    nstep(1, 17'h00005, 1);
    nt = 64'h20005;
    check("sticky_sum", n_sum_o, model_sum(nt, NAW));
    check("sticky_count", n_count_o, 3);
    check("sticky_flag", n_overflow_o, 1);
    nstep(0, '0, 0);
    check("n_drain_valid", n_valid_o, 0);

    // Reset mid-block discards the partial block.
    for (int i = 0; i < 3; i++) step(1, 5, 0, 1);
    do_reset();
    for (int i = 0; i < 8; i++) step(1, 1, 0, 1);
    check("rstblk_sum", sum_o, 8);
    check("rstblk_count", count_o, 8);
    step(0, 0, 0, 1);

    // Full-rate streaming: 1..8 then 9..16.
    for (int i = 1; i <= 8; i++) step(1, DW'(i), 0, 1);
    check("stream1_valid", valid_o, 1);
    check("stream1_sum", sum_o, 36);
    check("stream1_count", count_o, 8);
    for (int i = 9; i <= 16; i++) step(1, DW'(i), 0, 1);
    check("stream2_sum", sum_o, 100);
    step(0, 0, 0, 1);

    // Backpressure on the closing sample.
    for (int i = 1; i <= 8; i++) step(1, DW'(i), 0, 1);
    for (int i = 9; i <= 15; i++) step(1, DW'(i), 0, 0);
    step(1, 16, 0, 0);
    step(1, 16, 0, 0);
    check("bp_ready_low", ready_o, 0);
    check("bp_hold_sum", sum_o, 36);
    step(1, 16, 0, 1);
    check("bp_sum", sum_o, 100);
    check("bp_valid", valid_o, 1);
    step(0, 0, 0, 1);

    // Flush with the third sample, then an empty flush.
    step(1, 10, 0, 1);
    step(1, 20, 0, 1);
    step(1, 3, 1, 1);
    check("flush_sum", sum_o, 33);
    check("flush_count", count_o, 3);
    step(0, 0, 1, 1);
    step(0, 0, 1, 1);
    check("empty_flush_valid", valid_o, 0);

    // Randomized traffic.
    accepted = 0;
    cyc = 0;
    while (accepted < 10000 && cyc < 40000) begin
      step($urandom_range(0, 9) < 7, DW'($urandom), $urandom_range(0, 29) == 0,
           $urandom_range(0, 9) < 6);
      if (last_take) accepted++;
      cyc++;
    end
    check("random_samples_done", accepted >= 10000, 1);
    for (int i = 0; i < 2; i++) step(0, 0, 0, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
